// File: rtl/pmp_check_arbiter.sv
// pmp_check_arbiter: round-robin sharing of one combinational PMP checker between NR_REQ requesters
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_valid_i / req_ready_o       per-requester request handshake (ready one-hot or zero)
//   req_addr_i, req_access_type_i,
//   req_priv_lvl_i                  per-requester request payload
//   rsp_valid_o, rsp_id_o,
//   rsp_allow_o, rsp_ready_i        response channel, tagged with requester index
//   pmp_*_o, pmp_allow_i            shared checker port (allow is same-cycle)
//   cfg_update_i                    PMP CSR write this cycle; a LOOKUP result is discarded
module pmp_check_arbiter #(
  parameter int PLEN   = 34,
  parameter int NR_REQ = 3,
  localparam int IW    = $clog2(NR_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NR_REQ-1:0]             req_valid_i,
  output logic [NR_REQ-1:0]             req_ready_o,
  input  logic [NR_REQ-1:0][PLEN-1:0]   req_addr_i,
  input  logic [NR_REQ-1:0][2:0]        req_access_type_i,
  input  logic [NR_REQ-1:0][1:0]        req_priv_lvl_i,
  output logic                          rsp_valid_o,
  output logic [IW-1:0]                 rsp_id_o,
  output logic                          rsp_allow_o,
  input  logic [NR_REQ-1:0]             rsp_ready_i,
  output logic [PLEN-1:0]               pmp_addr_o,
  output logic [2:0]                    pmp_access_type_o,
  output logic [1:0]                    pmp_priv_lvl_o,
  input  logic                          pmp_allow_i,
  input  logic                          cfg_update_i
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, id_q, id_d, win;
  logic [PLEN-1:0] addr_q, addr_d;
  logic [2:0]      acc_q, acc_d;
  logic [1:0]      priv_q, priv_d;
  logic            allow_q, allow_d, found, hs, grant;
  // Scan from the highest offset down so the lowest cyclic offset from rr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(rr_q) + k) % NR_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + k) % NR_REQ);
      end
    end
  end
  always_comb begin
    hs          = state_q == RESP && rsp_ready_i[id_q];
    grant       = (state_q == IDLE || hs) && found;
    req_ready_o = grant ? NR_REQ'(1) << win : '0;
    rr_d        = grant ? (win == IW'(NR_REQ - 1) ? '0 : win + 1'b1) : rr_q;
    id_d        = grant ? win : id_q;
    addr_d      = grant ? req_addr_i[win] : addr_q;
    acc_d       = grant ? req_access_type_i[win] : acc_q;
    priv_d      = grant ? req_priv_lvl_i[win] : priv_q;
    allow_d     = (state_q == LOOKUP && !cfg_update_i) ? pmp_allow_i : allow_q;
    state_d     = state_q;
    case (state_q)
      IDLE:    state_d = grant ? LOOKUP : IDLE;
      LOOKUP:  state_d = cfg_update_i ? LOOKUP : RESP;
      RESP:    state_d = hs ? (grant ? LOOKUP : IDLE) : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      priv_q  <= '0;
      allow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
    end
  end
  assign rsp_valid_o       = state_q == RESP;
  assign rsp_id_o          = id_q;
  assign rsp_allow_o       = allow_q;
  assign pmp_addr_o        = addr_q;
  assign pmp_access_type_o = acc_q;
  assign pmp_priv_lvl_o    = priv_q;
endmodule

// File: tb/tb_pmp_check_arbiter.sv
// tb_pmp_check_arbiter: directed and randomized checks of pmp_check_arbiter against a transaction model
module tb_pmp_check_arbiter;
  localparam int PLEN = 34;
  localparam int NR   = 3;
  logic                    clk, rst;
  logic [NR-1:0]           req_valid, req_ready, rsp_ready;
  logic [NR-1:0][PLEN-1:0] req_addr;
  logic [NR-1:0][2:0]      req_acc;
  logic [NR-1:0][1:0]      req_priv;
  logic                    rsp_valid, rsp_allow, pmp_allow, cfg;
  logic [1:0]              rsp_id, pmp_priv;
  logic [PLEN-1:0]         pmp_addr;
  logic [2:0]              pmp_acc;
  int n_assert = 0;
  int n_fail   = 0;
  int m_rr, m_id;
  bit has_req, has_res;
  logic [PLEN-1:0] m_addr, a0;
  logic [2:0]      m_acc;
  logic [1:0]      m_priv;
  logic            m_allow;
  logic [2:0]      gseq [4];
  pmp_check_arbiter #(.PLEN(PLEN), .NR_REQ(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_access_type_i(req_acc), .req_priv_lvl_i(req_priv),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_allow_o(rsp_allow), .rsp_ready_i(rsp_ready),
    .pmp_addr_o(pmp_addr), .pmp_access_type_o(pmp_acc), .pmp_priv_lvl_o(pmp_priv),
    .pmp_allow_i(pmp_allow), .cfg_update_i(cfg)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [2:0] v, input logic c, input logic a, input logic [2:0] r);
    req_valid = v;
    cfg       = c;
    pmp_allow = a;
    rsp_ready = r;
    #1;
  endtask
  // One cycle of the reference model: check current outputs, then advance across the clock edge.
  task automatic tick();
    bit hs, found, gr;
    int w;
    if (rst) begin
      m_rr = 0; m_id = 0; has_req = 0; has_res = 0;
      m_addr = '0; m_acc = '0; m_priv = '0; m_allow = 1'b0;
    end
    hs    = has_res && rsp_ready[m_id];
    found = 0;
    w     = 0;
    for (int k = 0; k < NR; k++) begin
      if (!found && req_valid[(m_rr + k) % NR]) begin
        found = 1;
        w     = (m_rr + k) % NR;
      end
    end
    gr = (!has_req || hs) && found;
    chk("m_ready", req_ready, gr ? 64'(1 << w) : 64'd0);
    chk("m_rsp_valid", rsp_valid, has_res);
    chk("m_rsp_id", rsp_id, 64'(m_id));
    chk("m_pmp_addr", pmp_addr, m_addr);
    chk("m_pmp_acc", pmp_acc, m_acc);
    chk("m_pmp_priv", pmp_priv, m_priv);
    if (has_res || rst) chk("m_rsp_allow", rsp_allow, m_allow);
    if (!rst) begin
      if (has_req && !has_res && !cfg) begin
        m_allow = pmp_allow;
        has_res = 1;
      end else if (hs) begin
        has_req = 0;
        has_res = 0;
      end
      if (gr) begin
        m_id = w; m_addr = req_addr[w]; m_acc = req_acc[w]; m_priv = req_priv[w];
        has_req = 1; has_res = 0; m_rr = (w + 1) % NR;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rand_payload();
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = PLEN'({$urandom(), $urandom()});
      req_acc[i]  = 3'($urandom());
      req_priv[i] = 2'($urandom());
    end
  endtask
  initial begin
    gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst = 1'b1;
    rand_payload();
    drive(3'b000, 1'b0, 1'b0, 3'b111);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_addr", pmp_addr, 0);
    tick();
    drive(3'b110, 1'b0, 1'b0, 3'b111);
    chk("rst_ready_idle", req_ready, 3'b010);
    tick();
    rst = 1'b0;
    // single request from requester 1
    req_addr[1] = 34'h0_8000_0000; req_acc[1] = 3'b001; req_priv[1] = 2'b00;
    drive(3'b010, 1'b0, 1'b1, 3'b111);
    chk("t1_ready", req_ready, 3'b010);
    tick();
    drive(3'b000, 1'b0, 1'b1, 3'b111);
    chk("t1_addr", pmp_addr, 34'h0_8000_0000);
    tick();
    drive(3'b000, 1'b0, 1'b1, 3'b111);
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 1);
    chk("t1_allow", rsp_allow, 1'b1);
    tick();
    // all requesters valid, back-to-back round robin from rr=0
    rst = 1'b1; drive(3'b000, 1'b0, 1'b0, 3'b111); tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(3'b111, 1'b0, 1'b1, 3'b111);
      chk("rr_seq", req_ready, (i % 2 == 0) ? gseq[i / 2] : 3'b000);
      tick();
    end
    drive(3'b000, 1'b0, 1'b0, 3'b111); tick();
    // cfg_update holds LOOKUP for two cycles, final result is the third evaluation
    a0 = req_addr[0];
    drive(3'b001, 1'b0, 1'b1, 3'b111); tick();
    drive(3'b000, 1'b1, 1'b1, 3'b111); tick();
    drive(3'b000, 1'b1, 1'b1, 3'b111); tick();
    drive(3'b000, 1'b0, 1'b0, 3'b111);
    chk("cfg_not_yet", rsp_valid, 1'b0);
    tick();
    drive(3'b000, 1'b0, 1'b1, 3'b000);
    chk("cfg_valid", rsp_valid, 1'b1);
    chk("cfg_allow", rsp_allow, 1'b0);
    tick();
    // stalled response with noise on pmp_allow and cfg_update
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'(i % 2), 1'(i % 2 == 0), 3'b110);
      chk("stall_ready", req_ready, 3'b000);
      chk("stall_allow", rsp_allow, 1'b0);
      chk("stall_id", rsp_id, 0);
      chk("stall_addr", pmp_addr, a0);
      tick();
    end
    // reset while holding a response
    rst = 1'b1;
    drive(3'b110, 1'b0, 1'b0, 3'b000);
    chk("rst_drop", rsp_valid, 1'b0);
    tick();
    rst = 1'b0;
    drive(3'b110, 1'b0, 1'b0, 3'b111);
    chk("rst_first", req_ready, 3'b010);
    tick();
    drive(3'b000, 1'b0, 1'b0, 3'b111); tick();
    drive(3'b000, 1'b0, 1'b0, 3'b111); tick();
    // only requester 2 with rr=0, then rr wraps to 0
    rst = 1'b1; drive(3'b000, 1'b0, 1'b0, 3'b111); tick(); rst = 1'b0;
    drive(3'b100, 1'b0, 1'b1, 3'b111);
    chk("only2", req_ready, 3'b100);
    tick();
    drive(3'b000, 1'b0, 1'b1, 3'b111); tick();
    drive(3'b000, 1'b0, 1'b1, 3'b111); tick();
    drive(3'b111, 1'b0, 1'b1, 3'b111);
    chk("wrap0", req_ready, 3'b001);
    tick();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_payload();
      rst = ($urandom_range(79) == 0);
      drive(3'($urandom()), $urandom_range(3) == 0, 1'($urandom()), 3'($urandom()));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pmp_check_arbiter.md
# pmp_check_arbiter

Shares one combinational `pmp` checker between up to NR_REQ requesters, e.g. instruction fetch, load/store unit and page-table walker. Each requester sends a physical address, access type and privilege level over a valid/ready channel. The block arbitrates round-robin, registers the winning request, drives it onto the shared checker for one evaluation cycle, and returns the registered allow/deny result over a valid/ready response channel tagged with the requester index. It sits between the MMU-side requesters and the single `pmp` instance in the core.

## Interface
- `PLEN`, 34, physical address width (rv64: 56)
- `NR_REQ`, 3, number of requesters (≥2)
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset
- `req_valid_i`  in  NR_REQ  request valid per requester
- `req_ready_o`  out  NR_REQ  request accepted (one-hot or zero)
- `req_addr_i`  in  NR_REQ×PLEN  request address
- `req_access_type_i`  in  NR_REQ×3  `riscv::pmp_access_t` (bit0 R, bit1 W, bit2 X)
- `req_priv_lvl_i`  in  NR_REQ×2  `riscv::priv_lvl_t`
- `rsp_valid_o`  out  1  response valid
- `rsp_id_o`  out  $clog2(NR_REQ)  requester index of the response
- `rsp_allow_o`  out  1  PMP result for that request
- `rsp_ready_i`  in  NR_REQ  per-requester response ready; only `rsp_ready_i[rsp_id_o]` is used
- `pmp_addr_o`  out  PLEN  to `pmp.addr_i`
- `pmp_access_type_o`  out  3  to `pmp.access_type_i`
- `pmp_priv_lvl_o`  out  2  to `pmp.priv_lvl_i`
- `pmp_allow_i`  in  1  from `pmp.allow_o` (combinational, same cycle)
- `cfg_update_i`  in  1  a pmpcfg/pmpaddr CSR write takes effect this cycle

## Operation
- FSM states:
  - IDLE: no request held.
  - LOOKUP: held request is driven to `pmp`.
  - RESP: result is held.
- Grant window:
  - Open in IDLE.
  - Also open in RESP in the cycle the response handshakes (`rsp_ready_i[rsp_id_o]`=1).
- Arbitration: round-robin pointer `rr`. Winner is the first index i ≥ `rr` (cyclic) with `req_valid_i[i]`=1.
- `req_ready_o[winner]`=1 only in the grant window. It is combinational from `req_valid_i`. It is never asserted for an invalid requester.
- On grant:
  - Latch addr, access type, priv and id into the request register.
  - `rr` ← winner+1, wrapping from NR_REQ-1 to 0.
  - Next state LOOKUP.
- LOOKUP:
  - `pmp_*_o` drive the request register.
  - If `cfg_update_i`=0: capture `pmp_allow_i` into `rsp_allow_o` and go to RESP.
  - If `cfg_update_i`=1: discard, stay in LOOKUP and re-evaluate next cycle. Repeats while it stays high.
- RESP:
  - `rsp_valid_o`=1; `rsp_id_o` and `rsp_allow_o` are stable until handshake.
  - On handshake: go to LOOKUP if a grant happens in the same cycle, else IDLE.
  - `cfg_update_i` in RESP has no effect. The captured result stands.
- `pmp_*_o` always reflect the request register, including outside LOOKUP. They change only on grant.

## Timing
- Reset values (async, immediate):
  - State IDLE, `rr`=0.
  - `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_allow_o`=0.
  - `pmp_addr_o`=0, `pmp_access_type_o`=0, `pmp_priv_lvl_o`=0.
  - `req_ready_o` follows the IDLE rule, combinationally.
- Latency:
  - Grant in cycle T, LOOKUP in T+1, `rsp_valid_o`=1 in T+2.
  - Each cycle of `cfg_update_i` high in LOOKUP adds one cycle.
- Throughput: one request per 2 cycles, with back-to-back grant on response handshake.
- Reset mid-operation: held request and response are dropped. No response is issued for them.
- Simultaneous valid on all requesters: grant order is `rr`, `rr`+1, ... Each requester waits at most NR_REQ grants.
- A requester may deassert `req_valid_i` before grant. Once granted, its request is consumed.

## Test plan
- Reset, then req 1 with addr=0x8000_0000, access=R, priv=U, and `pmp_allow_i`=1 → `req_ready_o`=3'b010 in cycle T; `pmp_addr_o`=0x8000_0000 in T+1; `rsp_valid_o`=1, `rsp_id_o`=1, `rsp_allow_o`=1 in T+2.
- All 3 requesters valid continuously, `rsp_ready_i` always 1 → grants in order 0, 1, 2, 0 every 2 cycles; `rr` wraps from 2 to 0.
- `cfg_update_i`=1 for 2 cycles during LOOKUP; `pmp_allow_i` is 1, 1, then 0 → `rsp_valid_o` rises 2 cycles late with `rsp_allow_o`=0.
- Response stalled 4 cycles (`rsp_ready_i[id]`=0) while `pmp_allow_i` toggles and `cfg_update_i` pulses → `rsp_allow_o`, `rsp_id_o` and `pmp_*_o` stay stable; no `req_ready_o` asserted.
- `rst_i` asserted in RESP → `rsp_valid_o`=0 immediately, without waiting for a clock edge; after release the first grant goes to the lowest valid index.
- Only req 2 valid while `rr`=0 → req 2 granted, then `rr`=0.
